// File: rtl/lightpwm_pkg.sv
// Shared types and constants for the sensor acquisition scheduler.
// The optional watchdog is built only when SCHED_WATCHDOG_EN is defined.
package lightpwm_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ERR_CNT_W  = 8;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

   // State constants kept as plain localparams for legacy tools.
   typedef logic [1:0] sched_state_t;
   localparam sched_state_t ST_IDLE  = 2'd0;
   localparam sched_state_t ST_START = 2'd1;
   localparam sched_state_t ST_WAIT  = 2'd2;
   localparam sched_state_t ST_ABORT = 2'd3;

endpackage

// File: rtl/sensor_scheduler_tick_gen.sv
// Free-running acquisition tick: one pulse every PERIOD cycles while enable is high.
// Counter is parked at zero whenever enable is low.
module tick_gen #(
   parameter int PERIOD = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic tick
);

   localparam int CNT_W = $clog2(PERIOD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         r_count <= '0;
      end else if (r_count == CNT_LAST) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   // Gated so that dropping enable on the last count cannot launch a read.
   assign tick = enable && (r_count == CNT_LAST);

endmodule

// File: rtl/sensor_scheduler.sv
// Periodic sensor read scheduler: launches a read each tick and captures the result.
// Define SCHED_WATCHDOG_EN to add the WAIT timeout, abort pulse and error counter.
module sensor_scheduler
   import lightpwm_pkg::*;
#(
   parameter int PERIOD  = 1000,
   parameter int TIMEOUT = 256,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   output logic                 start,
   input  logic                 done,
   input  logic [DATA_W-1:0]    data_in,
   output logic [DATA_W-1:0]    sample,
   output logic                 sample_valid,
   output logic                 timeout_err,
   output logic                 overrun,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   if (PERIOD < 4 || TIMEOUT < 2) begin : g_param_check
      $error("sensor_scheduler: PERIOD must be >= 4 and TIMEOUT >= 2");
   end

   logic              w_tick;
   logic              w_done_ok;
   logic              w_expire;
   sched_state_t      r_state;
   sched_state_t      w_state_next;
   logic [DATA_W-1:0] r_sample;
   logic              r_sample_valid;
   logic              r_overrun;

   tick_gen #(
      .PERIOD (PERIOD)
   ) u_tick_gen (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .tick   (w_tick)
   );

   assign w_done_ok = (r_state == ST_WAIT) && done;

`ifdef SCHED_WATCHDOG_EN
   localparam int WAIT_W = $clog2(TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   logic [WAIT_W-1:0]    r_wait_cnt;
   logic [ERR_CNT_W-1:0] r_err_cnt;

   // Held at zero outside WAIT, so it always starts from zero on entry.
   always_ff @(posedge clk) begin
      if (rst || (r_state != ST_WAIT)) begin
         r_wait_cnt <= '0;
      end else begin
         r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_cnt <= '0;
      end else if ((r_state == ST_ABORT) && (r_err_cnt != ERR_CNT_MAX)) begin
         r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
   end

   // A done arriving on the last wait cycle takes priority over the abort.
   assign w_expire    = (r_state == ST_WAIT) && (r_wait_cnt == WAIT_LAST) && !done;
   assign timeout_err = (r_state == ST_ABORT);
   assign err_cnt     = r_err_cnt;
`else
   assign w_expire    = 1'b0;
   assign timeout_err = 1'b0;
   assign err_cnt     = '0;
`endif

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_tick) begin
               w_state_next = ST_START;
            end
         end
         ST_START: begin
            w_state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (done) begin
               w_state_next = ST_IDLE;
            end else if (w_expire) begin
               w_state_next = ST_ABORT;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_sample       <= '0;
         r_sample_valid <= 1'b0;
         r_overrun      <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_sample_valid <= w_done_ok;
         if (w_done_ok) begin
            r_sample <= data_in;
         end
         // Ticks that land mid-transaction are dropped, not queued.
         if (w_tick && (r_state != ST_IDLE)) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign start        = (r_state == ST_START);
   assign sample       = r_sample;
   assign sample_valid = r_sample_valid;
   assign overrun      = r_overrun;

endmodule

// File: tb/tb_sensor_scheduler.sv
// Randomised bench for sensor_scheduler against a transaction-age reference model.
// Watchdog-specific scenarios are compiled only when SCHED_WATCHDOG_EN is defined.
module tb_sensor_scheduler;

   localparam int PERIOD  = 16;
   localparam int TIMEOUT = 8;
   localparam int DW      = 8;
`ifdef SCHED_WATCHDOG_EN
   localparam bit WDOG = 1'b1;
`else
   localparam bit WDOG = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          done = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic          start;
   logic [DW-1:0] sample;
   logic          sample_valid;
   logic          timeout_err;
   logic          overrun;
   logic [7:0]    err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: m_age is cycles since the start pulse (-1 when no read is in flight).
   int         m_cnt = 0;
   int         m_age = -1;
   logic [7:0] m_sample = '0;
   logic       m_sv = 1'b0;
   logic       m_ovr = 1'b0;
   int         m_err = 0;
   bit         m_live = 1'b0;
   int         n_txn = 0;

   int cyc = 0;
   int pend = 0;
   int seg_lat = 3;
   int seg_data = -1;
   bit seg_spur = 1'b0;
   int obs_start = -1;
   int obs_sv = -1;
   int obs_to = -1;
   int n_start_obs = 0;

   sensor_scheduler #(
      .PERIOD  (PERIOD),
      .TIMEOUT (TIMEOUT),
      .DATA_W  (DW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .start        (start),
      .done         (done),
      .data_in      (data_in),
      .sample       (sample),
      .sample_valid (sample_valid),
      .timeout_err  (timeout_err),
      .overrun      (overrun),
      .err_cnt      (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_step(input logic r, input logic e, input logic d, input logic [7:0] x);
      bit tick;
      bit sv_n;
      if (r) begin
         m_cnt = 0; m_age = -1; m_sample = '0; m_sv = 1'b0;
         m_ovr = 1'b0; m_err = 0; m_live = 1'b1;
         return;
      end
      if (!m_live) return;
      tick  = e && (m_cnt == PERIOD - 1);
      m_cnt = e ? ((m_cnt + 1) % PERIOD) : 0;
      sv_n  = 1'b0;
      if (m_age < 0) begin
         if (tick) m_age = 0;
      end else begin
         if (tick) m_ovr = 1'b1;
         if (m_age == 0) begin
            m_age = 1;
         end else if (WDOG && m_age == TIMEOUT + 1) begin
            if (m_err < 255) m_err++;
            m_age = -1;
            n_txn++;
            $display("txn %0d cycle %0d: timeout, err_cnt now %0d", n_txn, cyc, m_err);
         end else if (d) begin
            m_sample = x;
            sv_n = 1'b1;
            m_age = -1;
            n_txn++;
            $display("txn %0d cycle %0d: sample 0x%02h", n_txn, cyc, x);
         end else if (WDOG && m_age == TIMEOUT) begin
            m_age = TIMEOUT + 1;
         end else begin
            m_age++;
         end
      end
      m_sv = sv_n;
   endtask

   // One clock: check this cycle's outputs, then apply this cycle's inputs.
   task automatic run_cycle(input logic r, input logic e, input logic d, input logic [7:0] x);
      @(negedge clk);
      if (m_live) begin
         check_val("start",        32'(start),        32'(m_age == 0));
         check_val("timeout_err",  32'(timeout_err),  32'(WDOG && m_age == TIMEOUT + 1));
         check_val("sample",       32'(sample),       32'(m_sample));
         check_val("sample_valid", 32'(sample_valid), 32'(m_sv));
         check_val("overrun",      32'(overrun),      32'(m_ovr));
         check_val("err_cnt",      32'(err_cnt),      32'(m_err));
      end
      if (start === 1'b1) begin
         n_start_obs++;
         if (obs_start < 0) obs_start = cyc;
      end
      if (sample_valid === 1'b1 && obs_sv < 0) obs_sv = cyc;
      if (timeout_err === 1'b1 && obs_to < 0) obs_to = cyc;
      rst = r; enable = e; done = d; data_in = x;
      model_step(r, e, d, x);
      cyc++;
   endtask

   function automatic int pick_lat();
      if (seg_lat >= 0) return seg_lat;
      if (seg_lat == -1) return 0;
      if ($urandom_range(0, 7) == 0) return 0;
      return int'($urandom_range(1, 12));
   endfunction

   // Sensor responder: answers a start with done after the segment's latency.
   task automatic auto_cycle(input logic e, input logic r);
      logic       d;
      logic [7:0] x;
      d = 1'b0;
      x = 8'($urandom);
      if (pend > 0) begin
         pend--;
         d = (pend == 0);
      end else if (seg_spur && $urandom_range(0, 11) == 0) begin
         d = 1'b1;
      end
      if (seg_data >= 0 && d) x = 8'(seg_data);
      if (m_age == 0) pend = pick_lat();
      run_cycle(r, e, d, x);
   endtask

   task automatic do_reset();
      repeat (2) run_cycle(1'b1, 1'b0, 1'b0, 8'h00);
      pend = 0;
   endtask

   initial begin
      int c0;
      int r_cyc;
      logic en;

      repeat (3) run_cycle(1'b1, 1'b0, 1'b0, 8'h00);

      // Nominal read: done three cycles after start.
      seg_lat = 3; seg_data = 8'h5A; seg_spur = 1'b0;
      obs_start = -1; obs_sv = -1; c0 = cyc;
      repeat (24) auto_cycle(1'b1, 1'b0);
      check_val("first_start_cycle", 32'(obs_start - c0), 32'(PERIOD));
      check_val("first_valid_cycle", 32'(obs_sv - c0), 32'd20);
      check_val("sample_5a", 32'(sample), 32'h5A);

      // Sensor never answers.
      seg_lat = -1; obs_start = -1; obs_to = -1;
      repeat (30) auto_cycle(1'b1, 1'b0);
`ifdef SCHED_WATCHDOG_EN
      check_val("timeout_delay", 32'(obs_to - obs_start), 32'd9);
      check_val("err_cnt_one", 32'(err_cnt), 32'd1);
      check_val("sample_kept", 32'(sample), 32'h5A);
`endif

      // Done lands on the final wait cycle.
      do_reset();
      seg_lat = TIMEOUT; seg_data = 8'h33; obs_to = -1;
      repeat (30) auto_cycle(1'b1, 1'b0);
      check_val("sample_33", 32'(sample), 32'h33);
      check_val("err_cnt_zero", 32'(err_cnt), 32'd0);
      check_val("no_timeout", 32'(obs_to), 32'hFFFF_FFFF);

      // Slow sensor: done 20 cycles after start.
      do_reset();
      seg_lat = 20; seg_data = 8'hC3; n_start_obs = 0;
      repeat (40) auto_cycle(1'b1, 1'b0);
`ifndef SCHED_WATCHDOG_EN
      check_val("overrun_set", 32'(overrun), 32'd1);
      check_val("single_start", 32'(n_start_obs), 32'd1);
      check_val("sample_c3", 32'(sample), 32'hC3);
`endif

      // Reset in the middle of WAIT, then a stale done.
      do_reset();
      seg_lat = -1; seg_data = -1;
      repeat (19) auto_cycle(1'b1, 1'b0);
      r_cyc = cyc;
      run_cycle(1'b1, 1'b1, 1'b0, 8'h00);
      pend = 0; obs_start = -1;
      run_cycle(1'b0, 1'b1, 1'b1, 8'hEE);
      seg_lat = 3;
      auto_cycle(1'b1, 1'b0);
      check_val("sample_after_rst", 32'(sample), 32'h00);
      repeat (17) auto_cycle(1'b1, 1'b0);
      check_val("start_after_rst", 32'(obs_start - r_cyc), 32'(PERIOD + 1));

`ifdef SCHED_WATCHDOG_EN
      // Long run of timeouts to saturate the error counter.
      do_reset();
      seg_lat = -1;
      repeat (260 * PERIOD + 30) auto_cycle(1'b1, 1'b0);
      check_val("err_cnt_saturated", 32'(err_cnt), 32'd255);
`endif

      // Random mix: latencies, missing answers, spurious done, enable toggles, resets.
      do_reset();
      seg_lat = -2; seg_data = -1; seg_spur = 1'b1;
      en = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 49) == 0) en = ~en;
         auto_cycle(en, ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL sim_watchdog: still running at time %0t, required to finish earlier", $time);
      $fatal(1, "bench did not terminate");
   end

endmodule
